// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch controller for the RV32I core.
// It reads the combinational, word-addressed instruction ROM and buffers the
// fetched words in a small prefetch queue. Decode takes the head of that queue
// over a valid/ready handshake. A redirect flushes the queue and restarts
// fetch at a new PC.
//
// Optional feature: define IMEM_FETCH_ALIGN_CHK_EN to trap misaligned redirect
// targets in a FAULT state. When it is undefined, redirect_pc[1:0] is ignored.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   fetch_en                    allow new fetches (the queue drains regardless)
//   mem_addr, mem_req           ROM address (= fetch_pc), fetch issued this cycle
//   mem_rdata                   ROM data for mem_addr, same cycle
//   inst_valid/data/pc          queue head presented to decode
//   inst_ready                  decode accepts the head
//   redirect_valid/redirect_pc  flush and restart fetch at redirect_pc
//   fetch_fault                 misaligned redirect seen (macro builds only)
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int PW = $clog2(QDEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } qent_t;

`ifdef IMEM_FETCH_ALIGN_CHK_EN
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;
`else
  typedef enum logic {RUN = 1'b0} state_t;
`endif

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc;
  qent_t         q [QDEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [PW:0]   cnt;
  logic          pop, push;
  logic [31:0]   tgt_pc;

  assign pop        = inst_valid & inst_ready;
  // A pop in this cycle frees a slot, so a full queue can still accept a push.
  assign push       = (state_q == RUN) & fetch_en & ~redirect_valid &
                      ((cnt < (PW+1)'(QDEPTH)) | pop);
  assign mem_req    = push & ~reset;
  assign mem_addr   = fetch_pc;
  assign tgt_pc     = {redirect_pc[31:2], 2'b00};

  // Head outputs are taken only from queue registers. There is no path from mem_rdata.
  assign inst_valid = (cnt != '0);
  assign inst_data  = q[rptr].inst;
  assign inst_pc    = q[rptr].pc;

`ifdef IMEM_FETCH_ALIGN_CHK_EN
  assign fetch_fault = (state_q == FAULT);

  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
  end
`else
  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];
  assign fetch_fault    = 1'b0;

  always_comb begin
    state_d = RUN;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rptr     <= '0;
      wptr     <= '0;
      cnt      <= '0;
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
    end else if (redirect_valid) begin
      // A flush drops every entry. An entry popped in this cycle is the older
      // instruction, and decode squashes it.
      fetch_pc <= tgt_pc;
      rptr     <= '0;
      wptr     <= '0;
      cnt      <= '0;
    end else begin
      if (push) begin
        q[wptr]  <= '{pc: fetch_pc, inst: mem_rdata};
        wptr     <= wptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rptr <= rptr + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl. A directed phase walks the start,
// backpressure, redirect, wrap, fetch_en and alignment scenarios. A random
// phase follows. Every cycle is compared against a queue-based reference model.
module tb_imem_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        clk = 1'b0;
  logic        reset, fetch_en, inst_ready, redirect_valid;
  logic [31:0] redirect_pc, mem_addr, mem_rdata, inst_data, inst_pc;
  logic        mem_req, inst_valid, fetch_fault;

  logic [31:0] rom [256];
  assign mem_rdata = rom[mem_addr[9:2]];

  imem_fetch_ctrl #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, inst} entries plus the next fetch address.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc    = RESET_PC;
  bit          m_fault = 0;
  bit          m_rst   = 0;

  function automatic bit exp_req();
    return !reset && !m_fault && fetch_en && !redirect_valid &&
           (mq.size() < QDEPTH || (mq.size() > 0 && inst_ready));
  endfunction

  task automatic check_outputs();
    chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req()});
    if (!reset) chk("mem_addr", mem_addr, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst_data", inst_data, mq[0].inst);
    end else if (m_rst) begin
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_inst_data", inst_data, 32'h0);
    end
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
  endtask

  task automatic model_update();
    bit req, pp;
    req = exp_req();
    pp  = (mq.size() > 0) && inst_ready;
    m_rst = reset;
    if (reset) begin
      mq.delete(); m_pc = RESET_PC; m_fault = 0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc & ~32'h3;
`ifdef IMEM_FETCH_ALIGN_CHK_EN
      m_fault = (redirect_pc % 4) != 0;
`endif
    end else begin
      if (pp) void'(mq.pop_front());
      if (req) begin
        mq.push_back('{pc: m_pc, inst: rom[m_pc[9:2]]});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit rdy,
                     input bit rv, input logic [31:0] rpc);
    reset = rst; fetch_en = en; inst_ready = rdy;
    redirect_valid = rv; redirect_pc = rpc;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run(input int n, input bit en, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, en, rdy, 0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0]  = 32'h0011_0233;   // ADD x4, x2, x1
    rom[41] = 32'h0080_00EF;   // JAL x1, +8
    reset = 1; fetch_en = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    @(posedge clk); #1;

    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    run(3, 1, 1);                        // start: pcs 0, 4, 8
    run(5, 1, 0);                        // backpressure
    run(4, 1, 1);
    run(3, 1, 0);                        // fill queue
    cyc(0, 1, 0, 1, 32'd164);            // redirect while full
    run(4, 1, 1);
    run(3, 1, 0);
    cyc(0, 1, 1, 1, 32'h40);             // redirect together with a pop
    run(3, 1, 1);
    cyc(0, 1, 1, 1, 32'hFFFF_FFF8);      // wrap
    run(4, 1, 1);
    run(2, 1, 0);
    run(4, 0, 1);                        // fetch_en low: drain, pc frozen
    cyc(0, 1, 1, 1, 32'h0000_00A2);      // misaligned redirect
    run(2, 1, 1);
    cyc(0, 1, 1, 1, 32'h0000_00A0);
    run(3, 1, 1);
    cyc(1, 1, 1, 0, 0);                  // mid-stream reset
    run(3, 1, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 99) < 85,
          $urandom_range(0, 99) < 60, $urandom_range(0, 15) == 0, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
